// File: rtl/cpu_pkg.sv
// cpu_pkg: shared widths, opcodes, ALU select and ALU function for simple_cpu
package cpu_pkg;
   localparam int DATA_W = 8;
   localparam int PC_W   = 32;
   localparam int NREG   = 8;
   localparam logic [7:0] OP_LOADI = 8'h00;
   localparam logic [7:0] OP_MOV   = 8'h01;
   localparam logic [7:0] OP_ADD   = 8'h02;
   localparam logic [7:0] OP_SUB   = 8'h03;
   localparam logic [7:0] OP_AND   = 8'h04;
   localparam logic [7:0] OP_OR    = 8'h05;
   localparam logic [7:0] OP_J     = 8'h06;
   localparam logic [7:0] OP_BEQ   = 8'h07;
   typedef enum logic [1:0] {ALU_FWD, ALU_ADD, ALU_AND, ALU_OR} alu_sel_t;
   // FWD passes operand b so loadi and mov share the write path
   function automatic logic [DATA_W-1:0] alu(input alu_sel_t sel, input logic [DATA_W-1:0] a,
                                             input logic [DATA_W-1:0] b);
      return sel == ALU_FWD ? b : sel == ALU_ADD ? a + b : sel == ALU_AND ? a & b : a | b;
   endfunction
endpackage

// File: rtl/reg_file.sv
// reg_file: eight 8-bit registers, two combinational read ports, one synchronous write port
//   clk, rst_n      : clock, asynchronous active-low clear of all registers
//   we, waddr, wdata: write enable, address, data
//   raddr1/rdata1, raddr2/rdata2: read ports
module reg_file
   import cpu_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we,
   input  logic [2:0]        waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [2:0]        raddr1,
   input  logic [2:0]        raddr2,
   output logic [DATA_W-1:0] rdata1,
   output logic [DATA_W-1:0] rdata2
);
   logic [DATA_W-1:0] reg_array [0:NREG-1];
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n)
         for (int i = 0; i < NREG; i++) reg_array[i] <= '0;
      else if (we)
         reg_array[waddr] <= wdata;
   assign rdata1 = reg_array[raddr1];
   assign rdata2 = reg_array[raddr2];
endmodule

// File: rtl/simple_cpu.sv
// simple_cpu: single-cycle 8-bit datapath core with 32-bit PC
//   CLK         : system clock, rising edge
//   RESET       : asynchronous active-low reset (PC and registers to 0)
//   INSTRUCTION : instruction word fetched at PC_OUT
//   PC_OUT      : current program counter (byte address)
module simple_cpu
   import cpu_pkg::*;
(
   input  logic            CLK,
   input  logic            RESET,
   input  logic [31:0]     INSTRUCTION,
   output logic [PC_W-1:0] PC_OUT
);
   logic [7:0] op, offset, imm;
   logic [2:0] rd, rt, rs;
   logic [DATA_W-1:0] rt_val, rs_val, operand_b, result;
   alu_sel_t alu_sel;
   logic we, is_sub, branch;
   logic [PC_W-1:0] pc_next;
   logic unused_bits;
   assign op     = INSTRUCTION[31:24];
   assign offset = INSTRUCTION[23:16];
   assign rd     = INSTRUCTION[18:16];
   assign rt     = INSTRUCTION[10:8];
   assign rs     = INSTRUCTION[2:0];
   assign imm    = INSTRUCTION[7:0];
   assign unused_bits = ^INSTRUCTION[15:11];
   reg_file u_regfile (
      .clk    (CLK),
      .rst_n  (RESET),
      .we     (we),
      .waddr  (rd),
      .wdata  (result),
      .raddr1 (rt),
      .raddr2 (rs),
      .rdata1 (rt_val),
      .rdata2 (rs_val)
   );
   // beq compares through the adder: equal operands give a zero difference
   always_comb begin
      is_sub    = op == OP_SUB || op == OP_BEQ;
      we        = op <= OP_OR;
      alu_sel   = (op == OP_ADD || is_sub) ? ALU_ADD : op == OP_AND ? ALU_AND :
                  op == OP_OR ? ALU_OR : ALU_FWD;
      operand_b = op == OP_LOADI ? imm : is_sub ? ~rs_val + 8'd1 : rs_val;
      result    = alu(alu_sel, rt_val, operand_b);
      branch    = op == OP_J || (op == OP_BEQ && result == '0);
      pc_next   = PC_OUT + 32'd4 + (branch ? {{22{offset[7]}}, offset, 2'b00} : 32'd0);
   end
   always_ff @(posedge CLK or negedge RESET)
      if (!RESET)
         PC_OUT <= '0;
      else
         PC_OUT <= pc_next;
endmodule

// File: tb/tb_simple_cpu.sv
// tb_simple_cpu: scoreboard bench for simple_cpu against an instruction-level model
module tb_simple_cpu;
   logic        CLK;
   logic        RESET;
   logic [31:0] INSTRUCTION;
   logic [31:0] PC_OUT;
   int errors = 0;
   int checks = 0;
   typedef struct {
      string       tag;
      logic [31:0] pc;
      logic [63:0] regs;
   } exp_t;
   exp_t sb[$];
   logic [7:0]  m_r [8];
   logic [31:0] m_pc;
   simple_cpu dut (
      .CLK         (CLK),
      .RESET       (RESET),
      .INSTRUCTION (INSTRUCTION),
      .PC_OUT      (PC_OUT)
   );
   initial CLK = 0;
   always #5 CLK = ~CLK;
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask
   function automatic logic [7:0] rr(input int i);
      return dut.u_regfile.reg_array[i];
   endfunction
   function automatic logic [63:0] dut_regs();
      logic [63:0] v;
      for (int i = 0; i < 8; i++) v[i*8 +: 8] = rr(i);
      return v;
   endfunction
   function automatic logic [63:0] model_regs();
      logic [63:0] v;
      for (int i = 0; i < 8; i++) v[i*8 +: 8] = m_r[i];
      return v;
   endfunction
   task automatic model_reset();
      m_pc = 0;
      for (int i = 0; i < 8; i++) m_r[i] = 0;
   endtask
   task automatic model(input logic [31:0] ins);
      logic [7:0]  a, b;
      logic [31:0] target;
      a = m_r[ins[10:8]];
      b = m_r[ins[2:0]];
      target = m_pc + 4 + 4 * {{24{ins[23]}}, ins[23:16]};
      case (ins[31:24])
         8'h00: m_r[ins[18:16]] = ins[7:0];
         8'h01: m_r[ins[18:16]] = b;
         8'h02: m_r[ins[18:16]] = a + b;
         8'h03: m_r[ins[18:16]] = a - b;
         8'h04: m_r[ins[18:16]] = a & b;
         8'h05: m_r[ins[18:16]] = a | b;
         default: ;
      endcase
      m_pc = (ins[31:24] == 8'h06 || (ins[31:24] == 8'h07 && a == b)) ? target : m_pc + 4;
   endtask
   task automatic step(input logic [31:0] ins, input string tag);
      exp_t e;
      INSTRUCTION = ins;
      model(ins);
      e.tag = tag;
      e.pc = m_pc;
      e.regs = model_regs();
      sb.push_back(e);
      @(posedge CLK);
      #1;
      e = sb.pop_front();
      check({e.tag, "_pc"}, PC_OUT, e.pc);
      check({e.tag, "_regs"}, dut_regs(), e.regs);
   endtask
   initial begin
      RESET = 0;
      INSTRUCTION = 32'h0001_0005;
      model_reset();
      repeat (3) @(posedge CLK);
      #1;
      check("rst_pc", PC_OUT, 0);
      check("rst_regs", dut_regs(), 0);
      RESET = 1;
      step(32'h0001_0005, "loadi_r1");
      step(32'h0002_0003, "loadi_r2");
      step(32'h0203_0102, "add_r3");
      step(32'h0304_0102, "sub_r4");
      check("pc_seq16", PC_OUT, 16);
      check("add_8", rr(3), 8'h08);
      check("sub_2", rr(4), 8'h02);
      step(32'h0702_0101, "beq_eq");
      check("beq_taken", PC_OUT, 28);
      step(32'h06FC_0000, "j_back");
      check("j_back16", PC_OUT, 16);
      step(32'h0702_0102, "beq_ne");
      check("beq_fall", PC_OUT, 20);
      step(32'h06FE_0000, "j_neg");
      check("j_neg16", PC_OUT, 16);
      step(32'h0305_0201, "sub_neg");
      check("sub_FE", rr(5), 8'hFE);
      step(32'h0001_000C, "loadi_0c");
      step(32'h0002_000A, "loadi_0a");
      step(32'h0106_0002, "mov_r6");
      step(32'h0403_0102, "and_r3");
      step(32'h0504_0102, "or_r4");
      check("mov_0a", rr(6), 8'h0A);
      check("and_08", rr(3), 8'h08);
      check("or_0e", rr(4), 8'h0E);
      step(32'h0001_00FF, "loadi_ff");
      step(32'h0002_0001, "loadi_01");
      step(32'h0007_0055, "loadi_r7");
      step(32'h0207_0102, "add_wrap");
      check("wrap_00", rr(7), 8'h00);
      step(32'h0000_0033, "loadi_r0");
      check("r0_write", rr(0), 8'h33);
      step(32'h0807_0102, "undef_08");
      step(32'hFF00_0000, "undef_ff");
      for (int i = 0; i < 6; i++)
         step({5'd0, 3'($urandom_range(0, 5)), 5'd0, 3'($urandom_range(0, 7)),
               8'($urandom_range(0, 7)), 8'($urandom)}, "rand_alu");
      RESET = 0;
      #1;
      check("mid_rst_pc", PC_OUT, 0);
      check("mid_rst_regs", dut_regs(), 0);
      INSTRUCTION = 32'h0001_0009;
      @(posedge CLK);
      #1;
      check("held_rst_pc", PC_OUT, 0);
      check("held_rst_regs", dut_regs(), 0);
      RESET = 1;
      model_reset();
      step(32'h0001_0007, "restart");
      check("restart_pc", PC_OUT, 4);
      check("restart_r1", rr(1), 8'h07);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
